// File: rtl/tc_sram_pkg.sv
// Shared constants and types for the tile-controller SRAM feed logic.
// Row count, SRAM_A depth, address width helper and feed FSM states.
package tc_sram_pkg;

  localparam int TC_ROWS     = 8;
  localparam int TC_A_ENTRYS = 16;

  function automatic int addr_w(input int entries);
    return (entries > 1) ? $clog2(entries) : 1;
  endfunction

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } feed_state_e;

endpackage

// File: rtl/sram_feed_row.sv
// One SRAM_A row read port: skewed read enable, address and data-valid.
// Row ROW_IDX reads entry t-ROW_IDX whenever that lands inside [0, Keff).
module sram_feed_row
  import tc_sram_pkg::*;
#(
  parameter int ROW_IDX = 0,
  parameter int AW      = 4,
  parameter int KW      = 5,
  parameter int TW      = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          issue,
  input  logic [TW-1:0] t,
  input  logic [KW-1:0] keff,
  output logic          re,
  output logic [AW-1:0] rdaddr,
  output logic          row_valid
);

  localparam int DW = TW + 2;
  localparam logic signed [DW-1:0] IDX = DW'(ROW_IDX);

  logic signed [DW-1:0] diff;
  logic signed [DW-1:0] keff_s;
  logic                 in_win;

  logic          re_q, re_d;
  logic [AW-1:0] rdaddr_q, rdaddr_d;
  logic          row_valid_q, row_valid_d;

  // Window test done in signed arithmetic so early steps never alias.
  always_comb begin
    diff   = $signed({2'b00, t}) - IDX;
    keff_s = $signed({{(DW-KW){1'b0}}, keff});
    in_win = !diff[DW-1] && (diff < keff_s);
  end

  // Next read enable/address; address holds while idle; valid trails re.
  always_comb begin
    re_d        = issue && in_win;
    rdaddr_d    = rdaddr_q;
    row_valid_d = re_q;
    if (re_d) begin
      rdaddr_d = diff[AW-1:0];
    end
  end

  // Row output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      re_q        <= 1'b0;
      rdaddr_q    <= '0;
      row_valid_q <= 1'b0;
    end else begin
      re_q        <= re_d;
      rdaddr_q    <= rdaddr_d;
      row_valid_q <= row_valid_d;
    end
  end

  assign re        = re_q;
  assign rdaddr    = rdaddr_q;
  assign row_valid = row_valid_q;

endmodule

// File: rtl/sram_a_feed_sched.sv
// SRAM_A read scheduler: systolically skewed per-row reads of K entries.
// Holds the IDLE/RUN/FLUSH FSM and the step counter t shared by all rows.
module sram_a_feed_sched
  import tc_sram_pkg::*;
#(
  parameter int ROWS   = TC_ROWS,
  parameter int ENTRYS = TC_A_ENTRYS,
  parameter int KW     = $clog2(ENTRYS) + 1,
  localparam int AW    = addr_w(ENTRYS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [KW-1:0]            k_len,
  input  logic                     stall,
  output logic [ROWS-1:0][AW-1:0]  rdaddr,
  output logic [ROWS-1:0]          re,
  output logic [ROWS-1:0]          row_valid,
  output logic                     busy,
  output logic                     done
);

  localparam int TW = $clog2(ENTRYS + ROWS) + 1;
  localparam logic [KW-1:0] KMAX = KW'(ENTRYS);
  localparam logic [TW-1:0] TAIL = TW'(ROWS - 1);

  feed_state_e   state_q, state_d;
  logic [TW-1:0] t_q, t_d;
  logic [KW-1:0] keff_q, keff_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [KW-1:0] keff_in;
  logic [TW-1:0] t_end;
  logic          issue;
  logic [TW-1:0] t_iss;
  logic [KW-1:0] keff_iss;

  // Clamp request length; t_end is the first t past the last row-7 read.
  always_comb begin
    keff_in = (k_len > KMAX) ? KMAX : k_len;
    t_end   = {{(TW-KW){1'b0}}, keff_q} + TAIL;
  end

  // FSM: the start edge already issues t=0 so row 0 reads the next cycle.
  always_comb begin
    state_d  = state_q;
    t_d      = t_q;
    keff_d   = keff_q;
    issue    = 1'b0;
    t_iss    = t_q;
    keff_iss = keff_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          keff_d = keff_in;
          t_d    = '0;
          if (keff_in == '0) begin
            state_d = FLUSH;
          end else begin
            state_d  = RUN;
            issue    = 1'b1;
            t_iss    = '0;
            keff_iss = keff_in;
            t_d      = TW'(1);
          end
        end
      end
      RUN: begin
        if (t_q == t_end) begin
          state_d = FLUSH;
        end else if (!stall) begin
          issue = 1'b1;
          t_d   = t_q + TW'(1);
        end
      end
      FLUSH: begin
        state_d = IDLE;
        t_d     = '0;
      end
      default: begin
        state_d = IDLE;
        t_d     = '0;
      end
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == FLUSH);
  end

  // Control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      t_q     <= '0;
      keff_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      keff_q  <= keff_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;

  for (genvar g = 0; g < ROWS; g++) begin : g_row
    sram_feed_row #(
      .ROW_IDX (g),
      .AW      (AW),
      .KW      (KW),
      .TW      (TW)
    ) u_row (
      .clk       (clk),
      .rst       (rst),
      .issue     (issue),
      .t         (t_iss),
      .keff      (keff_iss),
      .re        (re[g]),
      .rdaddr    (rdaddr[g]),
      .row_valid (row_valid[g])
    );
  end

endmodule
